// File: rtl/mem_bus_pkg.sv
// Shared definitions for initiators on the Mem_rd/Mem_wr strobe bus:
// FSM encoding, default memory map and bus signalling constants.
package mem_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_RESP   = 3'd4
  } mem_state_e;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1000_0000;
  localparam int unsigned DEFAULT_NUM_REGS  = 3;
  localparam logic        STROBE_ACTIVE     = 1'b0;
  localparam logic        STROBE_IDLE       = 1'b1;
  localparam int unsigned WORD_STRIDE       = 4;

endpackage

// File: rtl/mem_addr_check.sv
// Combinational legality decode for a word-addressed window on the strobe bus.
// The upper bound is formed in 33 bits so a window ending at 4 GiB cannot wrap.
module mem_addr_check
  import mem_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int unsigned NUM_REGS  = DEFAULT_NUM_REGS
) (
  input  logic [31:0] addr,
  output logic        legal
);

  localparam logic [32:0] LO_BOUND = {1'b0, BASE_ADDR};
  localparam logic [32:0] HI_BOUND = LO_BOUND + 33'(NUM_REGS) * 33'(WORD_STRIDE);

  logic [32:0] addr_ext_s;

  assign addr_ext_s = {1'b0, addr};

  // aligned and inside [LO_BOUND, HI_BOUND)
  always_comb begin
    legal = 1'b0;
    if ((addr[1:0] == 2'b00) && (addr_ext_s >= LO_BOUND) && (addr_ext_s < HI_BOUND)) begin
      legal = 1'b1;
    end else begin
      legal = 1'b0;
    end
  end

endmodule

// File: rtl/mem_master.sv
// Single-outstanding bus initiator: latches a core request, runs a
// SETUP/STROBE/HOLD strobe sequence and returns a one-cycle response.
module mem_master
  import mem_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int unsigned NUM_REGS  = DEFAULT_NUM_REGS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        Mem_rd,
  output logic        Mem_wr,
  output logic [31:0] Dir_Mem,
  output logic [31:0] Dato_Mem_in,
  input  logic [31:0] Dato_Mem_out
);

  mem_state_e  state_r, state_nxt_s;
  logic        we_r;
  logic [31:0] addr_r, wdata_r;
  logic        legal_s, accept_s;
  logic        cur_we_s;
  logic [31:0] cur_addr_s, cur_wdata_s;
  logic        in_window_s, strobing_s;
  logic        ready_nxt_s, rsp_valid_nxt_s, rsp_err_nxt_s, rd_nxt_s, wr_nxt_s;
  logic [31:0] rdata_nxt_s, dir_nxt_s, dato_nxt_s;

  mem_addr_check #(
    .BASE_ADDR (BASE_ADDR),
    .NUM_REGS  (NUM_REGS)
  ) u_addr_check (
    .addr  (req_addr),
    .legal (legal_s)
  );

  assign accept_s = (state_r == ST_IDLE) && req_valid;

  // next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          state_nxt_s = legal_s ? ST_SETUP : ST_RESP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETUP:  state_nxt_s = ST_STROBE;
      ST_STROBE: state_nxt_s = ST_HOLD;
      ST_HOLD:   state_nxt_s = ST_RESP;
      ST_RESP:   state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // next values for the registered bus and response outputs, keyed on the state being entered
  always_comb begin
    cur_we_s        = (state_r == ST_IDLE) ? req_we    : we_r;
    cur_addr_s      = (state_r == ST_IDLE) ? req_addr  : addr_r;
    cur_wdata_s     = (state_r == ST_IDLE) ? req_wdata : wdata_r;
    in_window_s     = state_nxt_s inside {ST_SETUP, ST_STROBE, ST_HOLD};
    strobing_s      = state_nxt_s inside {ST_STROBE, ST_HOLD};
    ready_nxt_s     = (state_nxt_s == ST_IDLE);
    rsp_valid_nxt_s = (state_nxt_s == ST_RESP);
    rsp_err_nxt_s   = accept_s && (state_nxt_s == ST_RESP);
    dir_nxt_s       = in_window_s ? cur_addr_s : 32'h0000_0000;
    dato_nxt_s      = (in_window_s && cur_we_s) ? cur_wdata_s : 32'h0000_0000;
    rd_nxt_s        = (strobing_s && !cur_we_s) ? STROBE_ACTIVE : STROBE_IDLE;
    wr_nxt_s        = (strobing_s && cur_we_s)  ? STROBE_ACTIVE : STROBE_IDLE;
    if ((state_r == ST_HOLD) && !we_r) begin
      rdata_nxt_s = Dato_Mem_out;
    end else begin
      rdata_nxt_s = 32'h0000_0000;
    end
  end

  // state register and request latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      we_r    <= 1'b0;
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        we_r    <= req_we;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
      end
    end
  end

  // registered outputs; reset forces strobes inactive immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= 32'h0000_0000;
      Mem_rd      <= STROBE_IDLE;
      Mem_wr      <= STROBE_IDLE;
      Dir_Mem     <= 32'h0000_0000;
      Dato_Mem_in <= 32'h0000_0000;
    end else begin
      req_ready   <= ready_nxt_s;
      rsp_valid   <= rsp_valid_nxt_s;
      rsp_err     <= rsp_err_nxt_s;
      rsp_rdata   <= rdata_nxt_s;
      Mem_rd      <= rd_nxt_s;
      Mem_wr      <= wr_nxt_s;
      Dir_Mem     <= dir_nxt_s;
      Dato_Mem_in <= dato_nxt_s;
    end
  end

endmodule

// File: tb/tb_mem_master.sv
// Randomised self-checking bench for mem_master with a small strobe-driven
// memory model and a transaction-level reference of the register contents.
module tb_mem_master;

  localparam logic [31:0]     BASE   = 32'h1000_0000;
  localparam longint unsigned BASE_L = 64'h1000_0000;
  localparam int              NREGS  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        Mem_rd, Mem_wr;
  logic [31:0] Dir_Mem, Dato_Mem_in, Dato_Mem_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] init_vals [NREGS];
  logic [31:0] bus_mem   [NREGS];
  logic [31:0] ref_mem   [NREGS];
  logic        load_mem;
  logic [31:0] bus_off;

  always #5 clk = ~clk;

  mem_master #(.BASE_ADDR(BASE), .NUM_REGS(NREGS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .Mem_rd(Mem_rd), .Mem_wr(Mem_wr), .Dir_Mem(Dir_Mem),
    .Dato_Mem_in(Dato_Mem_in), .Dato_Mem_out(Dato_Mem_out)
  );

  // memory model: drives read data while Mem_rd is low, stores on clock edges while Mem_wr is low
  assign bus_off = Dir_Mem - BASE;
  always_comb begin
    if (!Mem_rd && (bus_off < 32'd12)) Dato_Mem_out = bus_mem[bus_off[3:2]];
    else                               Dato_Mem_out = 32'h0;
  end
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < NREGS; i++) bus_mem[i] <= init_vals[i];
    end else if (!Mem_wr && (bus_off < 32'd12)) begin
      bus_mem[bus_off[3:2]] <= Dato_Mem_in;
    end
  end

  task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input string name);
    longint unsigned a;
    logic        legal, got, in_win, strobing, exp_rd, exp_wr;
    logic [31:0] exp_rdata, exp_dir, exp_dato, got_rdata;
    logic        got_err;
    int          idx, lat_exp, lat, bus_bad, w;
    a         = addr;
    legal     = (addr[1:0] == 2'b00) && (a >= BASE_L) && (a < BASE_L + 4 * NREGS);
    idx       = legal ? int'((a - BASE_L) / 4) : 0;
    exp_rdata = (legal && !we) ? ref_mem[idx] : 32'h0;
    lat_exp   = legal ? 4 : 1;
    got = 1'b0; lat = 0; bus_bad = 0; got_rdata = 32'h0; got_err = 1'b0;

    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    w = 0;
    while (req_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (w >= 20) begin
      n_fail++;
      $display("FAIL %s ready_wait: req_ready=%b expected 1 within 20 cycles", name, req_ready);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;

    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      in_win   = legal && (cyc <= 3);
      strobing = legal && (cyc >= 2) && (cyc <= 3);
      exp_dir  = in_win ? addr : 32'h0;
      exp_dato = (in_win && we) ? wdata : 32'h0;
      exp_rd   = !(strobing && !we);
      exp_wr   = !(strobing && we);
      if (Dir_Mem !== exp_dir || Dato_Mem_in !== exp_dato || Mem_rd !== exp_rd ||
          Mem_wr !== exp_wr || req_ready !== 1'b0) begin
        bus_bad++;
        $display("  %s cycle %0d: dir=%h/%h dato=%h/%h rd=%b/%b wr=%b/%b ready=%b/0", name, cyc,
                 Dir_Mem, exp_dir, Dato_Mem_in, exp_dato, Mem_rd, exp_rd, Mem_wr, exp_wr, req_ready);
      end
      if (rsp_valid === 1'b1) begin
        got = 1'b1; lat = cyc; got_rdata = rsp_rdata; got_err = rsp_err;
        break;
      end
    end

    n_checks++;
    if (!got || lat != lat_exp) begin
      n_fail++;
      $display("FAIL %s latency: got %0d (seen=%b) expected %0d", name, lat, got, lat_exp);
    end
    n_checks++;
    if (got_rdata !== exp_rdata) begin
      n_fail++;
      $display("FAIL %s rdata: got %h expected %h", name, got_rdata, exp_rdata);
    end
    n_checks++;
    if (got_err !== !legal) begin
      n_fail++;
      $display("FAIL %s err: got %b expected %b", name, got_err, !legal);
    end
    n_checks++;
    if (bus_bad != 0) begin
      n_fail++;
      $display("FAIL %s bus_sequence: %0d bad cycles expected 0", name, bus_bad);
    end

    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || Mem_rd !== 1'b1 || Mem_wr !== 1'b1 || Dir_Mem !== 32'h0) begin
      n_fail++;
      $display("FAIL %s after_resp: valid=%b ready=%b rd=%b wr=%b dir=%h expected 0 1 1 1 0",
               name, rsp_valid, req_ready, Mem_rd, Mem_wr, Dir_Mem);
    end
    if (legal && we) ref_mem[idx] = wdata;
  endtask

  task automatic test_reset();
    rst = 1'b1; load_mem = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 ||
        Mem_rd !== 1'b1 || Mem_wr !== 1'b1 || Dir_Mem !== 32'h0 || Dato_Mem_in !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_values: ready=%b valid=%b err=%b rdata=%h rd=%b wr=%b dir=%h dato=%h expected 1 0 0 0 1 1 0 0",
               req_ready, rsp_valid, rsp_err, rsp_rdata, Mem_rd, Mem_wr, Dir_Mem, Dato_Mem_in);
    end
    rst = 1'b0; load_mem = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || Mem_rd !== 1'b1 || Mem_wr !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_after_reset: ready=%b valid=%b rd=%b wr=%b expected 1 0 1 1",
               req_ready, rsp_valid, Mem_rd, Mem_wr);
    end
  endtask

  task automatic test_read();
    run_req(1'b0, 32'h1000_0004, 32'h0, "read_r2");
  endtask

  task automatic test_write_read();
    run_req(1'b1, 32'h1000_0008, 32'hDEAD_BEEF, "write_r3");
    run_req(1'b0, 32'h1000_0008, 32'h0, "readback_r3");
  endtask

  task automatic test_errors();
    run_req(1'b0, 32'h1000_000C, 32'h0, "err_past_end");
    run_req(1'b1, 32'h1000_0002, 32'h1234_5678, "err_misaligned");
    run_req(1'b0, 32'h0FFF_FFFC, 32'h0, "err_below_base");
    run_req(1'b1, 32'hFFFF_FFFC, 32'h1111_2222, "err_top_of_space");
  endtask

  task automatic test_random();
    logic [31:0] addr;
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0, 1:    addr = BASE + 32'(4 * $urandom_range(0, NREGS - 1));
        2:       addr = BASE + 32'($urandom_range(0, 15));
        default: addr = $urandom;
      endcase
      run_req(1'($urandom_range(0, 1)), addr, $urandom, "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] got_q [$];
    int          acc_q [$];
    int          n_acc, ready_low, err_seen;
    logic        accepting;
    addrs[0] = BASE; addrs[1] = BASE + 32'd4; addrs[2] = BASE + 32'd8;
    n_acc = 0; ready_low = 0; err_seen = 0;
    @(negedge clk);
    req_we = 1'b0; req_addr = addrs[0]; req_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      if (rsp_valid === 1'b1) begin
        got_q.push_back(rsp_rdata);
        if (rsp_err !== 1'b0) err_seen++;
      end
      if (n_acc > 0 && req_ready === 1'b0) ready_low++;
      if (got_q.size() == 3) break;
      accepting = (req_valid === 1'b1) && (req_ready === 1'b1);
      if (accepting) acc_q.push_back(c);
      @(posedge clk);
      #1;
      if (accepting) begin
        n_acc++;
        if (n_acc < 3) req_addr = addrs[n_acc];
        else           req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    n_checks++;
    if (acc_q.size() != 3 || (acc_q[1] - acc_q[0]) != 5 || (acc_q[2] - acc_q[1]) != 5) begin
      n_fail++;
      $display("FAIL b2b_spacing: %0d acceptances, gaps %0d/%0d expected 3 with gaps 5/5", acc_q.size(),
               (acc_q.size() > 1) ? acc_q[1] - acc_q[0] : -1, (acc_q.size() > 2) ? acc_q[2] - acc_q[1] : -1);
    end
    n_checks++;
    if (ready_low != 12) begin
      n_fail++;
      $display("FAIL b2b_ready_low: got %0d busy cycles expected 12", ready_low);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got_q.size() <= i || got_q[i] !== ref_mem[i] || err_seen != 0) begin
        n_fail++;
        $display("FAIL b2b_data[%0d]: got %h expected %h (responses %0d, errs %0d)", i,
                 (got_q.size() > i) ? got_q[i] : 32'hX, ref_mem[i], got_q.size(), err_seen);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    int pulses;
    pulses = 0;
    @(negedge clk);
    req_we = 1'b1; req_addr = BASE; req_wdata = 32'h5555_AAAA; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) pulses++;
    end
    n_checks++;
    if (Mem_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_in_hold: Mem_wr=%b expected 0 before reset", Mem_wr);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (Mem_wr !== 1'b1 || Mem_rd !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_strobe_release: rd=%b wr=%b expected 1 1", Mem_rd, Mem_wr);
    end
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) pulses++;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_no_response: pulses=%0d ready=%b expected 0 1", pulses, req_ready);
    end
    ref_mem[0] = bus_mem[0];
    run_req(1'b0, BASE + 32'd4, 32'h0, "read_after_abort");
  endtask

  initial begin
    init_vals[0] = 32'h1111_0000;
    init_vals[1] = 32'hA5A5_0001;
    init_vals[2] = 32'h3333_0002;
    for (int i = 0; i < NREGS; i++) ref_mem[i] = init_vals[i];
    test_reset();
    test_read();
    test_write_read();
    test_errors();
    test_random();
    test_back_to_back();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_master.md
# mem_master

Bus initiator for the word-addressed register memory on the `Mem_rd`/`Mem_wr` strobe interface. It accepts one read or write request at a time from the core-side valid/ready port and range-checks the address. It then runs a fixed multi-cycle strobe sequence on the memory bus and returns read data or an error flag as a one-cycle response pulse. It sits between the datapath load/store logic and the memory block.

## Interface
- `BASE_ADDR`, default 32'h1000_0000: address of the first mapped word.
- `NUM_REGS`, default 3: number of mapped 32-bit words, at `BASE_ADDR + 4*i`.
- `clk` input 1: system clock, rising-edge active.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: block can accept a request; high only in IDLE.
- `req_we` input 1: 1 = write, 0 = read.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: write data.
- `rsp_valid` output 1: one-cycle response pulse.
- `rsp_rdata` output 32: read data; 0 for writes and errors.
- `rsp_err` output 1: address unmapped or misaligned; valid with `rsp_valid`.
- `Mem_rd` output 1: active-low read strobe to memory.
- `Mem_wr` output 1: active-low write strobe to memory.
- `Dir_Mem` output 32: address to memory.
- `Dato_Mem_in` output 32: write data to memory.
- `Dato_Mem_out` input 32: read data from memory.

## Operation
- States: IDLE, SETUP, STROBE, HOLD, RESP.
- IDLE
  - `req_ready`=1.
  - On `req_valid` at a rising edge, latch `req_we`, `req_addr` and `req_wdata`.
  - If the address is legal, go to SETUP; otherwise go to RESP with err=1.
- Legal address: `addr[1:0]==0`, `addr >= BASE_ADDR` and `addr < BASE_ADDR + 4*NUM_REGS`.
  - The comparison is done in 33 bits so that `BASE_ADDR + 4*NUM_REGS` cannot wrap.
- SETUP
  - `Dir_Mem` = latched address.
  - `Dato_Mem_in` = latched wdata for writes, 0 for reads.
  - Both strobes stay high.
- STROBE: the selected strobe goes low (`Mem_rd` for a read, `Mem_wr` for a write). Address and data are held.
- HOLD
  - Strobe stays low and address/data are held.
  - For a read, `Dato_Mem_out` is captured into `rsp_rdata` at the edge leaving HOLD.
- RESP: `rsp_valid`=1 for exactly one cycle, both strobes high, then IDLE.
- Responses cannot be back-pressured. The consumer must take the response in the cycle `rsp_valid` is high.
- Both strobes are never low simultaneously. Memory gives read priority, so this rule is mandatory.
- Outside SETUP through HOLD: `Dir_Mem`=0, `Dato_Mem_in`=0, both strobes high.
- Errored requests never assert either strobe.
- Reset values:
  - state IDLE, `req_ready`=1.
  - `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0.
  - `Mem_rd`=1, `Mem_wr`=1.
  - `Dir_Mem`=0, `Dato_Mem_in`=0.

## Timing
- Request accepted at edge E0 with a legal address:
  - SETUP during E0–E1.
  - STROBE during E1–E2.
  - HOLD during E2–E3.
  - RESP during E3–E4.
  - `req_ready` high again after E4.
- Legal-request latency: `rsp_valid` high in the 4th cycle after acceptance. Throughput is one request per 5 cycles.
- Error latency: `rsp_valid` high in the cycle immediately after acceptance. Throughput is one request per 2 cycles.
- Strobe-low window: 2 full clock cycles, covering both clock edges, because memory responds on both clock levels. Address and data are stable for 1 cycle before the strobe falls and for the whole window.
- All bus outputs are registered; there are no combinational paths from request inputs to bus outputs.
- `req_valid` while not in IDLE is ignored. The requester must hold it until `req_ready`.
- Reset mid-transaction:
  - Strobes go high asynchronously and the state returns to IDLE.
  - No response is issued and the pending request is dropped.
  - A write aborted in STROBE or HOLD may or may not have landed in memory; that outcome is undefined.

## Structure
- Shared package `mem_bus_pkg`:
  - state encoding (IDLE, SETUP, STROBE, HOLD, RESP);
  - default `BASE_ADDR` and `NUM_REGS`;
  - strobe active level constant (0);
  - word stride constant (4).
- Sub-module `mem_addr_check`: combinational legal/illegal decode, parameterized by `BASE_ADDR` and `NUM_REGS`. It is reused by any future initiator on this bus.
- Top-level contents: FSM, request latch and output registers.

## Test plan
- Read 32'h1000_0004, memory r2 = 32'hA5A5_0001:
  - `Mem_rd` low exactly 2 cycles and `Mem_wr` high throughout;
  - `rsp_valid` 4 cycles after acceptance;
  - `rsp_rdata`=32'hA5A5_0001, `rsp_err`=0.
- Write 32'hDEAD_BEEF to 32'h1000_0008, then read the same address:
  - `Mem_wr` low 2 cycles with `Dato_Mem_in`=32'hDEAD_BEEF stable from SETUP through HOLD;
  - the read returns 32'hDEAD_BEEF.
- Address 32'h1000_000C, and separately 32'h1000_0002:
  - `rsp_err`=1 and `rsp_rdata`=0 in the cycle after acceptance;
  - no strobe ever goes low.
- Back-to-back: `req_valid` held high with 3 queued reads to r1, r2, r3:
  - exactly one acceptance per 5 cycles;
  - `req_ready` low during SETUP through RESP;
  - data returned in order.
- Assert `rst` during HOLD of a write:
  - `Mem_wr` rises within the same cycle and `rsp_valid` never pulses;
  - after release, `req_ready`=1 and a new read completes normally.
